// File: rtl/accel_pkg.sv
// Shared types for the accelerometer tilt classifier: axis state encoding,
// tilt bit positions and the committed-state to tilt-vector decode.
package accel_pkg;

  typedef enum logic [1:0] {
    NEUTRAL = 2'd0,
    POS     = 2'd1,
    NEG     = 2'd2
  } axis_state_t;

  localparam int TILT_LEFT  = 0;
  localparam int TILT_RIGHT = 1;
  localparam int TILT_FWD   = 2;
  localparam int TILT_BACK  = 3;

  localparam int AXIS_X = 0;
  localparam int AXIS_Y = 1;

  // Y high is left, Y low is right; X high is forward, X low is backward.
  function automatic logic [3:0] tilt_decode(input axis_state_t x_state,
                                             input axis_state_t y_state);
    logic [3:0] t;
    t             = 4'b0000;
    t[TILT_LEFT]  = (y_state == POS);
    t[TILT_RIGHT] = (y_state == NEG);
    t[TILT_FWD]   = (x_state == POS);
    t[TILT_BACK]  = (x_state == NEG);
    return t;
  endfunction

endpackage

// File: rtl/tilt_axis_fsm.sv
// One axis of the tilt classifier: threshold/hysteresis candidate plus debounce.
// With ACCEL_TILT_STICKY_EN defined a NEUTRAL candidate never commits.
module tilt_axis_fsm
  import accel_pkg::*;
#(
  parameter int unsigned DATA_W       = 12,
  parameter int unsigned HIGH_THR     = 9'h1C0,
  parameter int unsigned LOW_THR      = 9'h050,
  parameter int unsigned HYST         = 8'h10,
  parameter int unsigned DEBOUNCE_CNT = 3
) (
  input  logic              SYSCLK,
  input  logic              reset2,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] value,
  output axis_state_t       state_next
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CNT + 1);

  localparam logic [DATA_W-1:0] HIGH_ENTER = DATA_W'(HIGH_THR);
  localparam logic [DATA_W-1:0] HIGH_HOLD  = DATA_W'(HIGH_THR - HYST);
  localparam logic [DATA_W-1:0] LOW_ENTER  = DATA_W'(LOW_THR);
  localparam logic [DATA_W-1:0] LOW_HOLD   = DATA_W'(LOW_THR + HYST);
  localparam logic [CNT_W-1:0]  CNT_MAX    = CNT_W'(DEBOUNCE_CNT);
  localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);

  axis_state_t      state_reg;
  axis_state_t      pend_reg;
  axis_state_t      pend_next;
  axis_state_t      cand;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;
  logic [CNT_W-1:0] cnt_inc;

  // Entry thresholds win over hold bands; hold bands only keep the current state.
  always_comb begin
    cand = NEUTRAL;
    if (value >= HIGH_ENTER) begin
      cand = POS;
    end else if (value <= LOW_ENTER) begin
      cand = NEG;
    end else if ((state_reg == POS) && (value >= HIGH_HOLD)) begin
      cand = POS;
    end else if ((state_reg == NEG) && (value <= LOW_HOLD)) begin
      cand = NEG;
    end
`ifdef ACCEL_TILT_STICKY_EN
    if (cand == NEUTRAL) begin
      cand = state_reg;
    end
`endif
  end

  always_comb begin
    state_next = state_reg;
    pend_next  = pend_reg;
    cnt_next   = cnt_reg;
    cnt_inc    = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + 1'b1;
    if (sample_valid) begin
      if (cand == state_reg) begin
        cnt_next = '0;
      end else begin
        if (cand == pend_reg) begin
          cnt_next = cnt_inc;
        end else begin
          pend_next = cand;
          cnt_next  = CNT_ONE;
        end
        // Commit on the sample that completes the run; POS<->NEG is direct.
        if (cnt_next == CNT_MAX) begin
          state_next = pend_next;
          cnt_next   = '0;
        end
      end
    end
  end

  always_ff @(posedge SYSCLK) begin
    if (reset2) begin
      state_reg <= NEUTRAL;
      pend_reg  <= NEUTRAL;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      pend_reg  <= pend_next;
      cnt_reg   <= cnt_next;
    end
  end

endmodule

// File: rtl/accel_tilt_classifier.sv
// Two-axis accelerometer tilt classifier with debounced, hysteretic commits.
// Optional legacy sticky-tilt mode is selected by defining ACCEL_TILT_STICKY_EN.
module accel_tilt_classifier
  import accel_pkg::*;
#(
  parameter int unsigned DATA_W       = 12,
  parameter int unsigned HIGH_THR     = 9'h1C0,
  parameter int unsigned LOW_THR      = 9'h050,
  parameter int unsigned HYST         = 8'h10,
  parameter int unsigned DEBOUNCE_CNT = 3
) (
  input  logic              SYSCLK,
  input  logic              reset2,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] accel_x,
  input  logic [DATA_W-1:0] accel_y,
  output logic [3:0]        tilt,
  output logic              tilt_valid,
  output logic              tilt_changed
);

  // Hold bands must not overlap and the entry threshold must be representable.
  if ((longint'(LOW_THR) + longint'(HYST)) >= (longint'(HIGH_THR) - longint'(HYST))) begin : g_bad_hyst
    $error("accel_tilt_classifier: LOW_THR+HYST must be below HIGH_THR-HYST");
  end
  if (longint'(HIGH_THR) >= (longint'(1) << DATA_W)) begin : g_bad_high
    $error("accel_tilt_classifier: HIGH_THR does not fit in DATA_W bits");
  end
  if ((DEBOUNCE_CNT < 1) || (DEBOUNCE_CNT > 255)) begin : g_bad_debounce
    $error("accel_tilt_classifier: DEBOUNCE_CNT must be in 1..255");
  end

  logic [DATA_W-1:0] axis_value [2];
  axis_state_t       axis_next  [2];

  assign axis_value[AXIS_X] = accel_x;
  assign axis_value[AXIS_Y] = accel_y;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_axis
      tilt_axis_fsm #(
        .DATA_W       (DATA_W),
        .HIGH_THR     (HIGH_THR),
        .LOW_THR      (LOW_THR),
        .HYST         (HYST),
        .DEBOUNCE_CNT (DEBOUNCE_CNT)
      ) u_axis (
        .SYSCLK       (SYSCLK),
        .reset2       (reset2),
        .sample_valid (sample_valid),
        .value        (axis_value[gi]),
        .state_next   (axis_next[gi])
      );
    end
  endgenerate

  logic [3:0] tilt_reg;
  logic [3:0] tilt_next;
  logic       tilt_valid_reg;
  logic       tilt_changed_reg;

  // Decoding the axes' next state keeps the output one cycle behind the sample.
  assign tilt_next = tilt_decode(axis_next[AXIS_X], axis_next[AXIS_Y]);

  always_ff @(posedge SYSCLK) begin
    if (reset2) begin
      tilt_reg         <= 4'b0000;
      tilt_valid_reg   <= 1'b0;
      tilt_changed_reg <= 1'b0;
    end else begin
      tilt_valid_reg   <= sample_valid;
      tilt_changed_reg <= sample_valid && (tilt_next != tilt_reg);
      if (sample_valid) begin
        tilt_reg <= tilt_next;
      end
    end
  end

  assign tilt         = tilt_reg;
  assign tilt_valid   = tilt_valid_reg;
  assign tilt_changed = tilt_changed_reg;

endmodule

// File: tb/tb_accel_tilt_classifier.sv
// Scoreboard bench for accel_tilt_classifier: directed scenarios plus random
// samples checked against an arithmetic reference model of the tilt rules.
module tb_accel_tilt_classifier;

  localparam int DATA_W = 12;
  localparam int HI     = 'h1C0;
  localparam int LO     = 'h050;
  localparam int HY     = 'h010;
  localparam int DB     = 3;
`ifdef ACCEL_TILT_STICKY_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic              SYSCLK = 1'b0;
  logic              reset2;
  logic              sample_valid;
  logic [DATA_W-1:0] accel_x;
  logic [DATA_W-1:0] accel_y;
  logic [3:0]        tilt;
  logic              tilt_valid;
  logic              tilt_changed;

  always #5 SYSCLK = ~SYSCLK;

  accel_tilt_classifier #(
    .DATA_W       (DATA_W),
    .HIGH_THR     (HI),
    .LOW_THR      (LO),
    .HYST         (HY),
    .DEBOUNCE_CNT (DB)
  ) dut (
    .SYSCLK       (SYSCLK),
    .reset2       (reset2),
    .sample_valid (sample_valid),
    .accel_x      (accel_x),
    .accel_y      (accel_y),
    .tilt         (tilt),
    .tilt_valid   (tilt_valid),
    .tilt_changed (tilt_changed)
  );

  int         vectors     = 0;
  int         miscompares = 0;
  bit         mon_en      = 1'b0;
  logic [4:0] exp_q[$];

  // Reference model: 0 = level, 1 = high side, 2 = low side.
  int         m_cur  [2];
  int         m_pend [2];
  int         m_run  [2];
  logic [3:0] m_tilt;

  function automatic int model_cand(int v, int cur);
    int c;
    if (v >= HI) c = 1;
    else if (v <= LO) c = 2;
    else if (cur == 1 && v >= HI - HY) c = 1;
    else if (cur == 2 && v <= LO + HY) c = 2;
    else c = 0;
    if (STICKY && c == 0) c = cur;
    return c;
  endfunction

  function automatic void model_reset();
    for (int a = 0; a < 2; a++) begin
      m_cur[a] = 0; m_pend[a] = 0; m_run[a] = 0;
    end
    m_tilt = 4'b0000;
  endfunction

  function automatic void model_sample(int x, int y);
    logic [3:0] nt;
    for (int a = 0; a < 2; a++) begin
      int c;
      c = model_cand((a == 0) ? x : y, m_cur[a]);
      if (c == m_cur[a]) begin
        m_run[a] = 0;
      end else begin
        if (c == m_pend[a]) m_run[a] = (m_run[a] + 1 > DB) ? DB : m_run[a] + 1;
        else begin m_pend[a] = c; m_run[a] = 1; end
        if (m_run[a] >= DB) begin m_cur[a] = m_pend[a]; m_run[a] = 0; end
      end
    end
    nt = {m_cur[0] == 2, m_cur[0] == 1, m_cur[1] == 2, m_cur[1] == 1};
    exp_q.push_back({nt, nt != m_tilt});
    m_tilt = nt;
  endfunction

  task automatic step(input bit rst, input bit v, input int x, input int y);
    reset2       = rst;
    sample_valid = v;
    accel_x      = DATA_W'(x);
    accel_y      = DATA_W'(y);
    @(posedge SYSCLK);
    if (rst) begin
      model_reset();
      exp_q.delete();
    end else if (v) begin
      model_sample(x, y);
    end
    #1;
  endtask

  task automatic check_tilt(input logic [3:0] exp, input string name);
    vectors++;
    if (tilt !== exp) begin
      miscompares++;
      $display("FAIL %s: tilt=%b expected=%b", name, tilt, exp);
    end
  endtask

  task automatic check_bit(input logic act, input logic exp, input string name);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got=%b expected=%b", name, act, exp);
    end
  endtask

  // Monitor: pops one expectation per tilt_valid and tracks the held tilt value.
  always @(negedge SYSCLK) begin
    if (mon_en) begin
      logic [4:0] e;
      vectors++;
      if (tilt !== m_tilt) begin
        miscompares++;
        $display("FAIL held_tilt: tilt=%b expected=%b", tilt, m_tilt);
      end
      if ((tilt[0] && tilt[1]) || (tilt[2] && tilt[3])) begin
        miscompares++;
        $display("FAIL exclusive: tilt=%b has opposite bits set", tilt);
      end
      if (tilt_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL spurious_valid: tilt_valid=1 expected=0");
        end else begin
          e = exp_q.pop_front();
          vectors++;
          if (tilt !== e[4:1] || tilt_changed !== e[0]) begin
            miscompares++;
            $display("FAIL sample_out: tilt=%b changed=%b expected tilt=%b changed=%b",
                     tilt, tilt_changed, e[4:1], e[0]);
          end
        end
      end else if (tilt_valid !== 1'b0 || tilt_changed !== 1'b0) begin
        miscompares++;
        $display("FAIL idle_pulse: valid=%b changed=%b expected 0/0", tilt_valid, tilt_changed);
      end
    end
  end

  function automatic int pick_value();
    int r;
    r = $urandom_range(0, 12);
    case (r)
      0: return 'h000;
      1: return 'h040;
      2: return 'h050;
      3: return 'h051;
      4: return 'h060;
      5: return 'h061;
      6: return 'h100;
      7: return 'h1AF;
      8: return 'h1B0;
      9: return 'h1BF;
      10: return 'h1C0;
      11: return 'hFFF;
      default: return $urandom_range(0, 'hFFF);
    endcase
  endfunction

  initial begin
    reset2 = 1'b1; sample_valid = 1'b1; accel_x = 'h100; accel_y = 'h1F0;
    model_reset();
    // Reset held two cycles with a valid high-Y sample present.
    step(1, 1, 'h100, 'h1F0);
    step(1, 1, 'h100, 'h1F0);
    check_tilt(4'b0000, "reset_tilt");
    check_bit(tilt_valid, 1'b0, "reset_valid");
    check_bit(tilt_changed, 1'b0, "reset_changed");
    mon_en = 1'b1;

    // Two entry samples interrupted by a neutral one do not commit.
    step(0, 1, 'h100, 'h1C0);
    step(0, 1, 'h100, 'h1C0);
    step(0, 1, 'h100, 'h100);
    check_tilt(4'b0000, "interrupted_run");
    step(0, 1, 'h100, 'h1C0);
    step(0, 1, 'h100, 'h1C0);
    check_tilt(4'b0000, "left_after_two");
    step(0, 1, 'h100, 'h1C0);
    check_tilt(4'b0001, "left_commit");

    // Hold band keeps left; below the hold band returns to level.
    for (int i = 0; i < 5; i++) step(0, 1, 'h100, 'h1B5);
    check_tilt(4'b0001, "left_hyst_hold");
    step(0, 1, 'h100, 'h1AF);
    step(0, 1, 'h100, 'h1AF);
    check_tilt(4'b0001, "left_exit_pending");
    step(0, 1, 'h100, 'h1AF);
    check_tilt(STICKY ? 4'b0001 : 4'b0000, "left_exit");

    // Backward then direct swap to forward.
    for (int i = 0; i < 3; i++) step(0, 1, 'h040, 'h100);
    check_tilt(STICKY ? 4'b1001 : 4'b1000, "back_commit");
    step(0, 1, 'h1D0, 'h100);
    check_tilt(STICKY ? 4'b1001 : 4'b1000, "swap_step1");
    step(0, 1, 'h1D0, 'h100);
    check_tilt(STICKY ? 4'b1001 : 4'b1000, "swap_step2");
    step(0, 1, 'h1D0, 'h100);
    check_tilt(STICKY ? 4'b0101 : 4'b0100, "fwd_commit");
    for (int i = 0; i < 4; i++) begin
      step(0, 0, (i % 2) ? 'h000 : 'hFFF, 'h000);
      check_tilt(STICKY ? 4'b0101 : 4'b0100, "no_valid_hold");
    end

    // Reset in the middle of a debounce run discards the partial count.
    step(1, 0, 'h100, 'h100);
    step(0, 1, 'h100, 'h1C0);
    step(0, 1, 'h100, 'h1C0);
    step(1, 1, 'h100, 'h1C0);
    step(0, 1, 'h100, 'h1C0);
    step(0, 1, 'h100, 'h1C0);
    check_tilt(4'b0000, "mid_debounce_reset");

    // Neutral run behaviour, then direct left to right.
    step(0, 1, 'h100, 'h1C0);
    check_tilt(4'b0001, "left_again");
    for (int i = 0; i < 10; i++) step(0, 1, 'h100, 'h100);
    check_tilt(STICKY ? 4'b0001 : 4'b0000, "neutral_run");
    for (int i = 0; i < 3; i++) step(0, 1, 'h100, 'h040);
    check_tilt(4'b0010, "right_commit");

    // Randomised traffic with occasional resets and idle cycles.
    for (int i = 0; i < 3000; i++) begin
      bit r;
      bit v;
      r = ($urandom_range(0, 99) == 0);
      v = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 3) == 0) begin
        int x0;
        int y0;
        x0 = pick_value();
        y0 = pick_value();
        for (int k = 0; k < 4; k++) step(0, 1, x0, y0);
      end else begin
        step(r, v, pick_value(), pick_value());
      end
    end

    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d outputs outstanding, expected 0", exp_q.size());
    end
    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
